// File: rtl/instr_fetch_if.sv
// instr_fetch_if: instruction-memory read bus plus decode-side valid/ready handshake
interface instr_fetch_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_instr;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              halt;
  logic              instr_valid;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;
  modport master (
    output mem_addr, instr_valid, instr, instr_pc,
    input  mem_instr, redirect, redirect_pc, halt, instr_ready
  );
  modport slave (
    input  mem_addr, instr_valid, instr, instr_pc,
    output mem_instr, redirect, redirect_pc, halt, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: credit-based instruction fetch with FIFO, redirect flush and halt
// Optional FETCH_STATS_EN adds saturating stat_fetched / stat_killed counters.
module instr_fetch #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 32,
  parameter int RESET_PC   = 0,
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched,
  output logic [31:0]  stat_killed
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic {FETCH, HALTED} state_t;
  state_t            state, state_nx;
  logic [ADDR_W-1:0] addr, req_pc;
  logic              inflight, pop, push, issue;
  logic [DATA_W-1:0] d_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] p_mem [FIFO_DEPTH];
  logic [PW-1:0]     rp, wp, hp;
  logic [CW-1:0]     cnt;
  // when empty, show the last popped slot so instr/instr_pc hold their value
  assign hp              = (cnt == '0) ? rp - PW'(1) : rp;
  assign bus.mem_addr    = addr;
  assign bus.instr_valid = (cnt != '0);
  assign bus.instr       = d_mem[hp];
  assign bus.instr_pc    = p_mem[hp];
  assign pop             = bus.instr_valid & bus.instr_ready;
  assign push            = inflight & ~bus.redirect;
  always_comb begin
    state_nx = bus.halt ? HALTED : FETCH;
    issue    = (state == FETCH) & ~bus.halt & ~bus.redirect &
               ((cnt + CW'(inflight) - CW'(pop)) < CW'(FIFO_DEPTH));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FETCH;
      addr     <= ADDR_W'(RESET_PC);
      req_pc   <= '0;
      inflight <= 1'b0;
      rp       <= '0;
      wp       <= '0;
      cnt      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        d_mem[i] <= '0;
        p_mem[i] <= '0;
      end
    end else begin
      state    <= state_nx;
      inflight <= issue;
      if (issue) req_pc <= addr;
      addr <= bus.redirect ? bus.redirect_pc : issue ? addr + ADDR_W'(1) : addr;
      if (push) begin
        d_mem[wp] <= bus.mem_instr;
        p_mem[wp] <= req_pc;
      end
      rp  <= rp + PW'(pop);
      wp  <= bus.redirect ? rp + PW'(pop) : wp + PW'(push);
      cnt <= bus.redirect ? '0 : cnt + CW'(push) - CW'(pop);
    end
  end
`ifdef FETCH_STATS_EN
  logic [CW:0] kinc;
  logic [32:0] fsum, ksum;
  always_comb begin
    kinc = bus.redirect ? (CW+1)'(inflight) + (CW+1)'(cnt) - (CW+1)'(pop) : '0;
    fsum = {1'b0, stat_fetched} + 33'(push);
    ksum = {1'b0, stat_killed} + 33'(kinc);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_fetched <= '0;
      stat_killed  <= '0;
    end else begin
      stat_fetched <= fsum[32] ? '1 : fsum[31:0];
      stat_killed  <= ksum[32] ? '1 : ksum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of fetch sequence, back-pressure, redirect, wrap, halt, reset
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  instr_fetch_if #(.ADDR_W(22), .DATA_W(32)) bus();
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_killed;
`endif
  instr_fetch #(.ADDR_W(22), .DATA_W(32), .RESET_PC(0), .FIFO_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched(stat_fetched),
    .stat_killed(stat_killed)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [21:0] a);
    return {10'h2A5, a};
  endfunction
  // instruction memory: registered read, one cycle latency
  always @(posedge clk) bus.mem_instr <= f(bus.mem_addr);
  always @(posedge clk)
    if (rst && dut.cnt == 2'd2 && dut.push && !dut.pop) begin
      errors++;
      $display("FAIL overflow got push into full fifo exp no push");
    end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask
  task automatic test_reset;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.halt = 1'b0;
    bus.instr_ready = 1'b1;
    rst = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({bus.instr_valid, bus.mem_addr, bus.instr, bus.instr_pc} !== 77'd0) begin
      errors++;
      $display("FAIL reset_state got v=%b a=%h i=%h p=%h exp all zero",
               bus.instr_valid, bus.mem_addr, bus.instr, bus.instr_pc);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if ({stat_fetched, stat_killed} !== 64'd0) begin
      errors++;
      $display("FAIL reset_stats got %h %h exp 0 0", stat_fetched, stat_killed);
    end
`endif
  endtask
  task automatic test_sequence;
    do_reset();
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'd0}) begin
      errors++;
      $display("FAIL seq_c0 got v=%b a=%h exp v=0 a=0", bus.instr_valid, bus.mem_addr);
    end
    for (int i = 1; i <= 5; i++) begin
      cyc();
      checks++;
      if (bus.mem_addr !== 22'(i)) begin
        errors++;
        $display("FAIL seq_addr c%0d got %h exp %h", i, bus.mem_addr, 22'(i));
      end
      checks++;
      if (i == 1) begin
        if (bus.instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL seq_valid c1 got %b exp 0", bus.instr_valid);
        end
      end else if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 22'(i-2), f(22'(i-2))}) begin
        errors++;
        $display("FAIL seq_head c%0d got v=%b p=%h i=%h exp v=1 p=%h", i,
                 bus.instr_valid, bus.instr_pc, bus.instr, 22'(i-2));
      end
    end
  endtask
  task automatic test_backpressure;
    do_reset();
    cyc();
    cyc();
    bus.instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.mem_addr} !== {1'b1, 22'd0, f(22'd0), 22'd2}) begin
        errors++;
        $display("FAIL bp_hold k%0d got v=%b p=%h i=%h a=%h exp v=1 p=0 a=2", k,
                 bus.instr_valid, bus.instr_pc, bus.instr, bus.mem_addr);
      end
      cyc();
    end
    bus.instr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      checks++;
      if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 22'(j), f(22'(j))}) begin
        errors++;
        $display("FAIL bp_resume j%0d got v=%b p=%h i=%h exp p=%h", j,
                 bus.instr_valid, bus.instr_pc, bus.instr, 22'(j));
      end
      cyc();
    end
  endtask
  task automatic test_redirect;
    do_reset();
    repeat (6) cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 22'd4}) begin
      errors++;
      $display("FAIL rd_pre got v=%b p=%h exp v=1 p=4", bus.instr_valid, bus.instr_pc);
    end
    bus.instr_ready = 1'b0;
    bus.redirect = 1'b1;
    bus.redirect_pc = 22'h100;
    cyc();
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b1;
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'h100}) begin
      errors++;
      $display("FAIL rd_c1 got v=%b a=%h exp v=0 a=100", bus.instr_valid, bus.mem_addr);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if ({stat_fetched, stat_killed} !== {32'd5, 32'd2}) begin
      errors++;
      $display("FAIL rd_stats got f=%0d k=%0d exp f=5 k=2", stat_fetched, stat_killed);
    end
`endif
    cyc();
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'h101}) begin
      errors++;
      $display("FAIL rd_c2 got v=%b a=%h exp v=0 a=101", bus.instr_valid, bus.mem_addr);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 22'h100, f(22'h100)}) begin
      errors++;
      $display("FAIL rd_c3 got v=%b p=%h i=%h exp v=1 p=100", bus.instr_valid, bus.instr_pc, bus.instr);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 22'h101}) begin
      errors++;
      $display("FAIL rd_c4 got v=%b p=%h exp v=1 p=101", bus.instr_valid, bus.instr_pc);
    end
  endtask
  task automatic test_wrap;
    do_reset();
    repeat (3) cyc();
    bus.redirect = 1'b1;
    bus.redirect_pc = 22'h123;
    cyc();
    bus.redirect_pc = 22'h3FFFFF;
    cyc();
    bus.redirect = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'h3FFFFF}) begin
      errors++;
      $display("FAIL wrap_c1 got v=%b a=%h exp v=0 a=3fffff", bus.instr_valid, bus.mem_addr);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'h0}) begin
      errors++;
      $display("FAIL wrap_c2 got v=%b a=%h exp v=0 a=0", bus.instr_valid, bus.mem_addr);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 22'h3FFFFF, f(22'h3FFFFF)}) begin
      errors++;
      $display("FAIL wrap_c3 got v=%b p=%h i=%h exp p=3fffff", bus.instr_valid, bus.instr_pc, bus.instr);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 22'h0, f(22'h0)}) begin
      errors++;
      $display("FAIL wrap_c4 got v=%b p=%h i=%h exp p=0", bus.instr_valid, bus.instr_pc, bus.instr);
    end
  endtask
  task automatic test_halt;
    do_reset();
    repeat (4) cyc();
    bus.halt = 1'b1;
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.mem_addr} !== {1'b1, 22'd3, f(22'd3), 22'd4}) begin
      errors++;
      $display("FAIL halt_drain got v=%b p=%h i=%h a=%h exp v=1 p=3 a=4",
               bus.instr_valid, bus.instr_pc, bus.instr, bus.mem_addr);
    end
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++;
      if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'd4}) begin
        errors++;
        $display("FAIL halt_idle k%0d got v=%b a=%h exp v=0 a=4", k, bus.instr_valid, bus.mem_addr);
      end
`ifdef FETCH_STATS_EN
      checks++;
      if (stat_fetched !== 32'd4) begin
        errors++;
        $display("FAIL halt_stat k%0d got %0d exp 4", k, stat_fetched);
      end
`endif
    end
    bus.halt = 1'b0;
    cyc();
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'd4}) begin
      errors++;
      $display("FAIL halt_rel got v=%b a=%h exp v=0 a=4", bus.instr_valid, bus.mem_addr);
    end
    cyc();
    checks++;
    if (bus.mem_addr !== 22'd5) begin
      errors++;
      $display("FAIL halt_issue got a=%h exp a=5", bus.mem_addr);
    end
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr} !== {1'b1, 22'd4, f(22'd4)}) begin
      errors++;
      $display("FAIL halt_resume got v=%b p=%h i=%h exp p=4", bus.instr_valid, bus.instr_pc, bus.instr);
    end
`ifdef FETCH_STATS_EN
    checks++;
    if (stat_fetched !== 32'd5) begin
      errors++;
      $display("FAIL halt_stat_end got %0d exp 5", stat_fetched);
    end
`endif
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 22'd5}) begin
      errors++;
      $display("FAIL halt_next got v=%b p=%h exp p=5", bus.instr_valid, bus.instr_pc);
    end
  endtask
  task automatic test_reset_mid;
    do_reset();
    repeat (5) cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc} !== {1'b1, 22'd3}) begin
      errors++;
      $display("FAIL rm_pre got v=%b p=%h exp v=1 p=3", bus.instr_valid, bus.instr_pc);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'd0}) begin
      errors++;
      $display("FAIL rm_async got v=%b a=%h exp v=0 a=0", bus.instr_valid, bus.mem_addr);
    end
    cyc();
    rst = 1'b1;
    checks++;
    if ({bus.instr_valid, bus.mem_addr} !== {1'b0, 22'd0}) begin
      errors++;
      $display("FAIL rm_rel got v=%b a=%h exp v=0 a=0", bus.instr_valid, bus.mem_addr);
    end
    cyc();
    cyc();
    checks++;
    if ({bus.instr_valid, bus.instr_pc, bus.instr, bus.mem_addr} !== {1'b1, 22'd0, f(22'd0), 22'd2}) begin
      errors++;
      $display("FAIL rm_restart got v=%b p=%h i=%h a=%h exp v=1 p=0 a=2",
               bus.instr_valid, bus.instr_pc, bus.instr, bus.mem_addr);
    end
  endtask
  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
